// File: rtl/hazard_trace_buffer.sv
// hazard_trace_buffer: timestamped trace sink for the CPU hazard/debug outputs.
// Hazard cycles are pushed into a show-ahead FIFO drained over a valid/ready
// port, alongside saturating per-hazard counters and drop statistics.
module hazard_trace_buffer #(
   parameter int DEPTH = 16,
   parameter int TS_W  = 16,
   parameter int CNT_W = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_h1,
   input  logic                     i_h2,
   input  logic [8:0]               i_control,
   input  logic [31:0]              i_data,
   input  logic                     i_cap_en,
   input  logic                     i_clr,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [TS_W+42:0]         o_entry,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_overflow,
   output logic [CNT_W-1:0]         o_drop_cnt,
   output logic [CNT_W-1:0]         o_h1_cnt,
   output logic [CNT_W-1:0]         o_h2_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = TS_W + 43;
   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   logic [TS_W-1:0] ts;
   logic [EW-1:0]   mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     level;

   logic cap_event;
   logic pop;
   logic full;
   logic push;
   logic drop;

   // A push into a full FIFO is still allowed when the head leaves in the
   // same cycle; only a full FIFO with no pop discards the event.
   assign cap_event = i_cap_en & (i_h1 | i_h2);
   assign full      = (level == FULL_LEVEL);
   assign pop       = o_valid & i_ready;
   assign push      = cap_event & (~full | pop);
   assign drop      = cap_event & full & ~pop;

   // The head is read straight out of the storage registers so it is
   // visible in the same cycle o_valid rises; forced to zero when empty so
   // reset and clear present an all-zero entry without clearing storage.
   assign o_valid = (level != '0);
   assign o_entry = o_valid ? mem[rd_ptr] : '0;
   assign o_level = level;

   // Entry storage; clear suppresses the write so a cleared FIFO stays empty.
   always_ff @(posedge i_clk) begin
      if (push && !i_clr) begin
         mem[wr_ptr] <= {ts, i_h2, i_h1, i_control, i_data};
      end
   end

   // Timestamp, pointers, occupancy, sticky overflow and saturating counters.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ts         <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         o_overflow <= 1'b0;
         o_drop_cnt <= '0;
         o_h1_cnt   <= '0;
         o_h2_cnt   <= '0;
      end else if (i_clr) begin
         ts         <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         o_overflow <= 1'b0;
         o_drop_cnt <= '0;
         o_h1_cnt   <= '0;
         o_h2_cnt   <= '0;
      end else begin
         ts <= ts + 1'b1;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (drop) begin
            o_overflow <= 1'b1;
            if (o_drop_cnt != '1) begin
               o_drop_cnt <= o_drop_cnt + 1'b1;
            end
         end
         if (i_h1 && (o_h1_cnt != '1)) begin
            o_h1_cnt <= o_h1_cnt + 1'b1;
         end
         if (i_h2 && (o_h2_cnt != '1)) begin
            o_h2_cnt <= o_h2_cnt + 1'b1;
         end
      end
   end

endmodule
